// File: rtl/backward_sub_nxn_pkg.sv
// Shared definitions for the matrix_inv datapath: back-substitution FSM
// encoding, accumulator width rule, W-bit saturation and row-major packing.
package matrix_inv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_DIV,
    S_WRITE,
    S_DONE
  } bs_state_e;

  // Working width of the saturation helper; wide enough for any legal ACCW.
  localparam int unsigned SAT_VW = 256;

  // Accumulator width: full product plus output fraction plus row growth.
  function automatic int unsigned accw(input int unsigned w, input int unsigned xfrac,
                                       input int unsigned n);
    return 2 * w + xfrac + $clog2(n);
  endfunction

  // Clamp a signed value into the signed range of a w-bit word.
  function automatic logic signed [SAT_VW-1:0] sat_clamp(input logic signed [SAT_VW-1:0] v,
                                                         input int unsigned w);
    logic signed [SAT_VW-1:0] hi;
    logic signed [SAT_VW-1:0] lo;
    hi = (SAT_VW'(1) << (w - 1)) - SAT_VW'(1);
    lo = -hi - SAT_VW'(1);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Flat element index of (r,c) in a row-major n x n matrix.
  function automatic int unsigned elem_idx(input int unsigned r, input int unsigned c,
                                           input int unsigned n);
    return r * n + c;
  endfunction

endpackage

// File: rtl/backward_sub_nxn_div.sv
// seq_signed_div: ACCW-cycle restoring divider on magnitudes with sign fix.
// Ports: clk, rst_n, go (launch, first iteration happens on the go edge),
// dividend/divisor (signed ACCW), busy (further iterations remain beyond the
// current cycle; drops for the final iteration so a caller can leave its wait
// state in lockstep), done (pulse while quotient is fresh), quotient
// (signed, truncated toward zero). Divisor is never zero.
module seq_signed_div #(
  parameter int unsigned ACCW = 66
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   go,
  input  logic signed [ACCW-1:0] dividend,
  input  logic signed [ACCW-1:0] divisor,
  output logic                   busy,
  output logic                   done,
  output logic signed [ACCW-1:0] quotient
);

  localparam int unsigned CW = $clog2(ACCW + 1);

  logic [ACCW:0]          rem_q, rem_d;
  logic [ACCW-1:0]        quo_q, quo_d;
  logic [ACCW-1:0]        dsr_q, dsr_d;
  logic                   neg_q, neg_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic signed [ACCW-1:0] res_q, res_d;

  logic [ACCW:0]   src_rem_c, rem_sh_c;
  logic [ACCW-1:0] src_quo_c, src_dsr_c, quo_sh_c;
  logic            step_c;

  function automatic logic [ACCW-1:0] mag(input logic signed [ACCW-1:0] v);
    return v[ACCW-1] ? ACCW'(-v) : ACCW'(v);
  endfunction

  // One restoring step per cycle; go seeds the step from the operands directly.
  always_comb begin
    rem_d     = rem_q;
    quo_d     = quo_q;
    dsr_d     = dsr_q;
    neg_d     = neg_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    res_d     = res_q;
    step_c    = 1'b0;
    src_rem_c = rem_q;
    src_quo_c = quo_q;
    src_dsr_c = dsr_q;
    if (go) begin
      step_c    = 1'b1;
      src_rem_c = '0;
      src_quo_c = mag(dividend);
      src_dsr_c = mag(divisor);
      dsr_d     = src_dsr_c;
      neg_d     = dividend[ACCW-1] ^ divisor[ACCW-1];
      cnt_d     = CW'(ACCW - 1);
      busy_d    = 1'b1;
    end else if (cnt_q != '0) begin
      step_c = 1'b1;
      cnt_d  = cnt_q - 1'b1;
      busy_d = (cnt_q > CW'(2));
      done_d = (cnt_q == CW'(1));
    end
    rem_sh_c = {src_rem_c[ACCW-1:0], src_quo_c[ACCW-1]};
    quo_sh_c = {src_quo_c[ACCW-2:0], 1'b0};
    if (step_c) begin
      if (rem_sh_c >= {1'b0, src_dsr_c}) begin
        rem_d = rem_sh_c - {1'b0, src_dsr_c};
        quo_d = quo_sh_c | ACCW'(1);
      end else begin
        rem_d = rem_sh_c;
        quo_d = quo_sh_c;
      end
    end
    if (done_d) res_d = neg_q ? -signed'(quo_d) : signed'(quo_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
      neg_q  <= 1'b0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      res_q  <= '0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dsr_q  <= dsr_d;
      neg_q  <= neg_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      res_q  <= res_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = res_q;

endmodule

// File: rtl/backward_sub_nxn.sv
// backward_sub_nxn: solves U*x = y for upper-triangular U in signed fixed point.
// Ports: clk, rst_n (async active-low), start (accepted in IDLE only),
// U_in (row-major N*N*W, Q(FRAC)), y_in (N*W, Q(FRAC)), busy, done (1-cycle
// pulse), singular (valid with done), x_out (N*W, Q(XFRAC), held between solves).
module backward_sub_nxn
  import matrix_inv_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned W     = 32,
  parameter int unsigned FRAC  = 14,
  parameter int unsigned XFRAC = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N*N*W-1:0] U_in,
  input  logic [N*W-1:0]   y_in,
  output logic             busy,
  output logic             done,
  output logic             singular,
  output logic [N*W-1:0]   x_out
);

  localparam int unsigned ACCW = accw(W, XFRAC, N);
  localparam int unsigned IW   = $clog2(N);

  if (N < 2 || N > 8 || FRAC >= W) begin : g_bad_param
    $error("backward_sub_nxn: unsupported N/W/FRAC combination");
  end

  bs_state_e              state_q, state_d;
  logic signed [W-1:0]    u_q [N][N];
  logic signed [W-1:0]    u_d [N][N];
  logic signed [W-1:0]    y_q [N];
  logic signed [W-1:0]    y_d [N];
  logic signed [W-1:0]    x_q [N];
  logic signed [W-1:0]    x_d [N];
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic [IW-1:0]          row_q, row_d;
  logic [IW-1:0]          col_q, col_d;
  logic                   first_q, first_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   sing_q, sing_d;
  logic [N*W-1:0]         xo_q, xo_d;

  logic signed [2*W-1:0]  prod_c;
  logic                   div_go_c;
  logic                   div_busy, div_done;
  logic signed [ACCW-1:0] div_quot;

  function automatic logic signed [ACCW-1:0] y_scaled(input logic signed [W-1:0] v);
    return {{(ACCW - W){v[W-1]}}, v} <<< XFRAC;
  endfunction

  seq_signed_div #(.ACCW(ACCW)) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .go      (div_go_c),
    .dividend(acc_q),
    .divisor ({{(ACCW - W){u_q[row_q][row_q][W-1]}}, u_q[row_q][row_q]}),
    .busy    (div_busy),
    .done    (div_done),
    .quotient(div_quot)
  );

  // Next-state and datapath for the row-by-row solve.
  always_comb begin
    state_d  = state_q;
    u_d      = u_q;
    y_d      = y_q;
    x_d      = x_q;
    acc_d    = acc_q;
    row_d    = row_q;
    col_d    = col_q;
    first_d  = first_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sing_d   = sing_q;
    xo_d     = xo_q;
    div_go_c = 1'b0;
    prod_c   = u_q[row_q][col_q] * x_q[col_q];
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int unsigned r = 0; r < N; r++) begin
            for (int unsigned c = 0; c < N; c++) u_d[r][c] = U_in[elem_idx(r, c, N)*W +: W];
            y_d[r] = y_in[r*W +: W];
          end
          sing_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        row_d   = IW'(N - 1);
        acc_d   = y_scaled(y_q[N-1]);
        first_d = 1'b1;
        state_d = S_DIV;
      end
      S_MAC: begin
        acc_d = acc_q - {{(ACCW - 2*W){prod_c[2*W-1]}}, prod_c};
        if (col_q == IW'(N - 1)) begin
          first_d = 1'b1;
          state_d = S_DIV;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      S_DIV: begin
        // First DIV cycle screens the pivot; a zero pivot aborts the solve.
        if (first_q) begin
          first_d = 1'b0;
          if (u_q[row_q][row_q] == '0) begin
            sing_d = 1'b1;
            for (int unsigned i = 0; i < N; i++) x_d[i] = '0;
            state_d = S_DONE;
          end else begin
            div_go_c = 1'b1;
          end
        end else if (!div_busy) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (div_done) begin
          x_d[row_q] = W'(sat_clamp({{(SAT_VW - ACCW){div_quot[ACCW-1]}}, div_quot}, W));
        end
        if (row_q == '0) begin
          state_d = S_DONE;
        end else begin
          row_d   = row_q - 1'b1;
          col_d   = row_q;
          acc_d   = y_scaled(y_q[row_q - 1'b1]);
          state_d = S_MAC;
        end
      end
      S_DONE: begin
        for (int unsigned i = 0; i < N; i++) xo_d[i*W +: W] = x_q[i];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      for (int unsigned r = 0; r < N; r++) begin
        for (int unsigned c = 0; c < N; c++) u_q[r][c] <= '0;
        y_q[r] <= '0;
        x_q[r] <= '0;
      end
      acc_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      first_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sing_q  <= 1'b0;
      xo_q    <= '0;
    end else begin
      state_q <= state_d;
      u_q     <= u_d;
      y_q     <= y_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
      row_q   <= row_d;
      col_q   <= col_d;
      first_q <= first_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sing_q  <= sing_d;
      xo_q    <= xo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign singular = sing_q;
  assign x_out    = xo_q;

endmodule

// File: tb/tb_backward_sub_nxn.sv
// Directed bench for backward_sub_nxn: three parameterisations driven in turn.
module tb_backward_sub_nxn;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // A: defaults (N=4, W=32, FRAC=14, XFRAC=0)
  logic         sa, busy_a, done_a, sing_a;
  logic [511:0] ua;
  logic [127:0] ya, xa;
  // B: N=4, W=32, FRAC=14, XFRAC=8
  logic         sb, busy_b, done_b, sing_b;
  logic [511:0] ub;
  logic [127:0] yb, xb;
  // C: N=2, W=16, FRAC=8, XFRAC=0
  logic         sc, busy_c, done_c, sing_c;
  logic [63:0]  uc;
  logic [31:0]  yc, xc;

  backward_sub_nxn dut_a (.clk(clk), .rst_n(rst_n), .start(sa), .U_in(ua), .y_in(ya),
                          .busy(busy_a), .done(done_a), .singular(sing_a), .x_out(xa));
  backward_sub_nxn #(.N(4), .W(32), .FRAC(14), .XFRAC(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(sb), .U_in(ub), .y_in(yb),
    .busy(busy_b), .done(done_b), .singular(sing_b), .x_out(xb));
  backward_sub_nxn #(.N(2), .W(16), .FRAC(8), .XFRAC(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(sc), .U_in(uc), .y_in(yc),
    .busy(busy_c), .done(done_c), .singular(sing_c), .x_out(xc));

  int ncmp = 0;
  int nfail = 0;
  int um[16];
  int yv[4];

  localparam logic [127:0] X1 = {32'd3, 32'hFFFF_FFFC, 32'd2, 32'd5};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] pack_u(input int m[16]);
    logic [511:0] v;
    for (int k = 0; k < 16; k++) v[k*32 +: 32] = 32'(m[k]);
    return v;
  endfunction

  function automatic logic [127:0] pack_y(input int m[4]);
    logic [127:0] v;
    for (int k = 0; k < 4; k++) v[k*32 +: 32] = 32'(m[k]);
    return v;
  endfunction

  function automatic logic done_of(input int sel);
    case (sel)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0:       sa = v;
      1:       sb = v;
      default: sc = v;
    endcase
  endtask

  // Count edges until done is seen (bounded); lat counts from the start edge.
  task automatic wait_done(input int sel, input string tag, output int lat);
    lat = 0;
    while (lat < 2000) begin
      @(posedge clk);
      lat++;
      #1;
      if (done_of(sel)) break;
    end
    chk({tag, "_done_seen"}, 128'(done_of(sel)), 128'(1));
  endtask

  task automatic start_and_wait(input int sel, input string tag, output int lat);
    @(negedge clk);
    set_start(sel, 1'b1);
    @(posedge clk);
    #1;
    set_start(sel, 1'b0);
    wait_done(sel, tag, lat);
  endtask

  task automatic load_s1();
    um = '{65536, 32768, 49152, 16384, 0, 32768, 16384, 32768,
           0, 0, 16384, 49152, 0, 0, 0, 32768};
    yv = '{294912, 114688, 81920, 98304};
    ua = pack_u(um);
    ya = pack_y(yv);
  endtask

  initial begin
    int lat;
    int extra;
    rst_n = 1'b0;
    sa = 1'b0; sb = 1'b0; sc = 1'b0;
    ua = '0; ya = '0; ub = '0; yb = '0; uc = '0; yc = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 128'(busy_a), 128'(0));
    chk("rst_done", 128'(done_a), 128'(0));
    chk("rst_singular", 128'(sing_a), 128'(0));
    chk("rst_x_out", xa, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Scenario 1: nominal 4x4 solve with exact latency
    load_s1();
    start_and_wait(0, "s1", lat);
    chk("s1_latency", 128'(lat), 128'(276));
    chk("s1_singular", 128'(sing_a), 128'(0));
    chk("s1_x_out", xa, X1);
    chk("s1_busy_at_done", 128'(busy_a), 128'(0));
    @(posedge clk);
    #1;
    chk("s1_done_pulse_len", 128'(done_a), 128'(0));
    chk("s1_x_held", xa, X1);

    // Scenario 2: XFRAC=8, U = 2.0*I, y = 1.0 -> x = 0.5 in Q8
    um = '{32768, 0, 0, 0, 0, 32768, 0, 0, 0, 0, 32768, 0, 0, 0, 0, 32768};
    yv = '{16384, 16384, 16384, 16384};
    ub = pack_u(um);
    yb = pack_y(yv);
    start_and_wait(1, "s2", lat);
    chk("s2_latency", 128'(lat), 128'(308));
    chk("s2_x_out", xb, {32'd128, 32'd128, 32'd128, 32'd128});

    // Scenario 4: saturation both ways with raw identity U
    um = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    yv = '{1073741824, 0, 0, 0};
    ub = pack_u(um);
    yb = pack_y(yv);
    start_and_wait(1, "sat_pos", lat);
    chk("sat_pos_x_out", xb, 128'h7FFF_FFFF);
    yv = '{-1073741824, 0, 0, 0};
    yb = pack_y(yv);
    start_and_wait(1, "sat_neg", lat);
    chk("sat_neg_x_out", xb, 128'h8000_0000);

    // Scenario 3: zero pivot in row 2, then an immediate restart in the done cycle
    load_s1();
    um[10] = 0;
    ua = pack_u(um);
    start_and_wait(0, "sing", lat);
    chk("sing_singular", 128'(sing_a), 128'(1));
    chk("sing_x_out", xa, 128'(0));
    load_s1();
    sa = 1'b1;
    @(posedge clk);
    #1;
    sa = 1'b0;
    chk("restart_busy", 128'(busy_a), 128'(1));
    chk("restart_singular_clr", 128'(sing_a), 128'(0));
    wait_done(0, "restart", lat);
    chk("restart_latency", 128'(lat), 128'(276));
    chk("restart_x_out", xa, X1);

    // Start held high for the whole solve, including the DONE cycle
    @(negedge clk);
    sa = 1'b1;
    @(posedge clk);
    #1;
    wait_done(0, "held", lat);
    sa = 1'b0;
    chk("held_latency", 128'(lat), 128'(276));
    chk("held_busy_after", 128'(busy_a), 128'(0));
    extra = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done_a) extra++;
    end
    chk("held_extra_done", 128'(extra), 128'(0));
    chk("held_x_out", xa, X1);

    // Inputs scrambled mid-solve must not disturb the result
    start_and_wait(0, "pre_mid", lat);
    @(negedge clk);
    sa = 1'b1;
    @(posedge clk);
    #1;
    sa = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    for (int k = 0; k < 16; k++) ua[k*32 +: 32] = $urandom;
    for (int k = 0; k < 4; k++) ya[k*32 +: 32] = $urandom;
    wait_done(0, "mid", lat);
    chk("mid_latency", 128'(lat), 128'(236));
    chk("mid_x_out", xa, X1);
    chk("mid_singular", 128'(sing_a), 128'(0));

    // Reset while in the MAC phase of row 1
    load_s1();
    @(negedge clk);
    sa = 1'b1;
    @(posedge clk);
    #1;
    sa = 1'b0;
    repeat (137) @(posedge clk);
    #1;
    chk("pre_rst_busy", 128'(busy_a), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 128'(busy_a), 128'(0));
    chk("mid_rst_done", 128'(done_a), 128'(0));
    chk("mid_rst_singular", 128'(sing_a), 128'(0));
    chk("mid_rst_x_out", xa, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    start_and_wait(0, "post_rst", lat);
    chk("post_rst_latency", 128'(lat), 128'(276));
    chk("post_rst_x_out", xa, X1);

    // N=2, W=16, FRAC=8: U = [[2.0,1.0],[0,4.0]], y = (4.0,-8.0) -> x = (3,-2)
    uc = {16'd1024, 16'd0, 16'd256, 16'd512};
    yc = {16'hF800, 16'd1024};
    start_and_wait(2, "n2", lat);
    chk("n2_latency", 128'(lat), 128'(71));
    chk("n2_singular", 128'(sing_c), 128'(0));
    chk("n2_x_out", 128'(xc), 128'({16'hFFFE, 16'd3}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/backward_sub_nxn.md
Name: backward_sub_nxn

Overview:
- Parametrised N x N upper-triangular back-substitution engine. Solves U·x = y in signed fixed point.
- Successor to the fixed 4x4 backward block: generic N, W and fractional formats, an output fractional format, singular-pivot detection, saturation and a busy/done handshake.
- Sits after the forward-substitution stage in the matrix_inv datapath.

Parameters:
- N, 4, matrix dimension (2..8).
- W, 32, signed word width of U, y and x elements.
- FRAC, 14, fractional bits of U and y (Q-format shared by both).
- XFRAC, 0, fractional bits of x_out.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request. Sampled only in IDLE.
- U_in  in  N*N*W  row-major. Element (r,c) is at bits [(r*N+c)*W +: W]. Entries below the diagonal are ignored.
- y_in  in  N*W  element i is at bits [i*W +: W].
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at the end of a solve.
- singular  out  1  valid with done; held until the next accepted start.
- x_out  out  N*W  element i is at bits [i*W +: W], in Q(XFRAC). Held stable between solves.

Behaviour:
- Reset (asynchronous, rst_n=0) drives busy=0, done=0, singular=0, x_out=0 and the FSM to IDLE. Any solve in progress is discarded.
- Start acceptance:
  - start=1 in IDLE: latch U_in and y_in into internal registers, clear singular, go to LOAD.
  - start while busy is ignored. Later changes on U_in/y_in have no effect on the solve.
- FSM states: IDLE -> LOAD -> (MAC -> DIV -> WRITE) per row -> DONE -> IDLE.
- Row order: i = N-1 down to 0.
- LOAD (1 cycle): i=N-1, acc = sign-extended y[i] << XFRAC.
- MAC: one cycle per j = i+1..N-1, performing acc -= U[i][j]*x[j]. Row N-1 skips MAC (0 cycles).
- DIV:
  - If U[i][i]==0: set singular, zero all x results, go to DONE. No divide is performed.
  - Otherwise start the sequential divider with acc / U[i][i]. It takes ACCW cycles.
- WRITE (1 cycle): x[i] = quotient saturated to W bits.
  - If i==0, go to DONE.
  - Otherwise decrement i, load acc = y[i] << XFRAC and go to MAC.
- DONE (1 cycle): copy x to x_out, pulse done, busy=0.
- Arithmetic:
  - ACCW = 2W + XFRAC + clog2(N). Every product and the accumulator are signed at ACCW bits. Nothing wraps.
  - Division is signed and truncates toward zero, matching Verilog "/".
  - Saturation clamps to +(2^(W-1)-1) and -(2^(W-1)).
  - Format: the Q(FRAC+XFRAC) accumulator divided by a Q(FRAC) pivot gives Q(XFRAC).
- Latency from the start edge to done high: 2 + N*(ACCW+1) + N(N-1)/2 cycles, where the +1 per row is WRITE.
  - Early exit on a singular pivot at row k takes fewer cycles.
  - The latency is data-independent otherwise.
- done and a new start cannot overlap: start in the DONE cycle is ignored. start in the following IDLE cycle is accepted.

Decomposition:
- Shared package matrix_inv_pkg holds:
  - FSM state encoding (IDLE, LOAD, MAC, DIV, WRITE, DONE);
  - the ACCW function;
  - the saturation function;
  - element-index helper functions for row-major packing.
- One sub-module, seq_signed_div:
  - parameter ACCW;
  - ports clk, rst_n, go, dividend, divisor, busy, done, quotient;
  - restoring divide on magnitudes with a sign fix;
  - divide-by-zero is never issued to it.

Test Plan:
- Default parameters; U rows (65536,32768,49152,16384), (0,32768,16384,32768), (0,0,16384,49152), (0,0,0,32768); y = (294912,114688,81920,98304) -> x_out = (5,2,-4,3), singular=0, done exactly at the computed latency.
- XFRAC=8, U = 32768·I, y all 16384 -> x_out all 128 (0.5).
- U[2][2]=0, otherwise as in the first scenario -> done with singular=1, x_out all 0. A following valid start clears singular.
- XFRAC=8, U = I·1 (raw), y[0] = 2^30 -> x_out[0] = 0x7FFFFFFF. Also negate y[0] -> 0x80000000.
- start pulsed every cycle during a solve; separately, U_in and y_in changed mid-solve -> a single done and unchanged results.
- rst_n low during MAC of row 1 -> all outputs 0 immediately. The next start solves correctly. Repeat the first scenario with N=2, W=16, FRAC=8.
